// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the stack-machine command sequencer.
// Holds the opcode and FSM state enumerations and the default word and stack sizes.
// Also provides a helper that classifies the two-operand opcodes.
package stack_seq_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_NOT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH_A = 2'd1,
        ST_FETCH_B = 2'd2,
        ST_WRITE   = 2'd3
    } state_e;

    // ADD/SUB/AND/OR consume two stack entries.
    function automatic logic is_binary(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Purpose: combinational datapath producing the word written back to the stack.
// Ports: op_i selects the function, a_i = top operand (or immediate for PUSH), b_i = second operand, y_o = result.
// Zero latency; no handshake, purely combinational.
module stack_alu
#(
    parameter int W = 8
)
(
    input  stack_seq_pkg::op_e op_i,
    input  logic [W-1:0]       a_i,
    input  logic [W-1:0]       b_i,
    output logic [W-1:0]       y_o
);
    import stack_seq_pkg::*;

    // Operand order matches the stack: b is the older entry, so SUB is b - a.
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_PUSH: y_o = a_i;
            OP_ADD:  y_o = b_i + a_i;
            OP_SUB:  y_o = b_i - a_i;
            OP_AND:  y_o = b_i & a_i;
            OP_OR:   y_o = b_i | a_i;
            OP_NOT:  y_o = ~a_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Purpose: initiator for an external LIFO; runs one stack-machine command at a time via pop/push strobes.
// Ports: cmd_* valid/ready command in; stk_* strobes/data to and top-of-stack from the stack; result/status pulses and depth out.
// Latency accept->result_valid: PUSH 2, POP 2, NOT 3, binary 4; errors pulse 1 cycle after accept. cmd_ready only in IDLE.
module stack_op_sequencer
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 6
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              err_underflow,
    output logic              err_overflow,
    output logic [CNT_W-1:0]  depth
);
    import stack_seq_pkg::*;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

    state_e            state_q;
    op_e               op_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic              err_underflow_q;
    logic              err_overflow_q;
    logic [CNT_W-1:0]  depth_q;

    op_e               cmd_op_e;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_y;

    assign cmd_op_e = op_e'(cmd_op);

    // PUSH reuses the ALU as a pass-through so stk_din has a single source.
    assign alu_a = (op_q == OP_PUSH) ? imm_q : a_q;

    stack_alu #(.W(DATA_W)) u_alu (
        .op_i (op_q),
        .a_i  (alu_a),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_NOP;
            imm_q           <= '0;
            a_q             <= '0;
            b_q             <= '0;
            result_q        <= '0;
            result_valid_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            depth_q         <= '0;
        end else begin
            result_valid_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op_e;
                        imm_q <= cmd_imm;
                        // Depth checks happen here so a rejected command never strobes the stack.
                        case (cmd_op_e)
                            OP_NOP: ;
                            OP_PUSH: begin
                                if (depth_q == FULL) err_overflow_q <= 1'b1;
                                else                 state_q        <= ST_WRITE;
                            end
                            OP_POP, OP_NOT: begin
                                if (depth_q < ONE) err_underflow_q <= 1'b1;
                                else               state_q         <= ST_FETCH_A;
                            end
                            default: begin
                                if (depth_q < TWO) err_underflow_q <= 1'b1;
                                else               state_q         <= ST_FETCH_A;
                            end
                        endcase
                    end
                end
                ST_FETCH_A: begin
                    a_q     <= stk_dout;
                    depth_q <= depth_q - ONE;
                    if (op_q == OP_POP) begin
                        result_q       <= stk_dout;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else if (is_binary(op_q)) begin
                        state_q <= ST_FETCH_B;
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_FETCH_B: begin
                    // stk_dout now shows the entry below the one popped in FETCH_A.
                    b_q     <= stk_dout;
                    depth_q <= depth_q - ONE;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    result_q       <= alu_y;
                    result_valid_q <= 1'b1;
                    depth_q        <= depth_q + ONE;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes, so push and pop are mutually exclusive by construction.
    assign cmd_ready     = (state_q == ST_IDLE);
    assign stk_pop       = (state_q == ST_FETCH_A) || (state_q == ST_FETCH_B);
    assign stk_push      = (state_q == ST_WRITE);
    assign stk_din       = alu_y;
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
    assign depth         = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer with a behavioural 32-entry stack attached.
// A reference stack model predicts each completion (kind, value, depth, cycle, strobe counts) into a queue;
// a negedge monitor pops and compares whenever the DUT reports a completion or an error.
module tb_stack_op_sequencer;

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, ADD = 3'b011,
                           SUB = 3'b100, AND_ = 3'b101, OR_ = 3'b110, NOT_ = 3'b111;

    typedef struct {
        int kind;      // 0 ok, 1 underflow, 2 overflow
        int value;
        int dep;
        int cyc;
        int pops;
        int pushes;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [7:0] cmd_imm = 8'h00;
    logic       stk_push, stk_pop;
    logic [7:0] stk_din, stk_dout, result;
    logic       result_valid, err_underflow, err_overflow;
    logic [5:0] depth;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pops_seen = 0;
    int pushes_seen = 0;
    evt_t sb[$];
    int   mstk[$];

    logic [7:0] mem [0:31];
    int sp = 0;

    stack_op_sequencer #(.DATA_W(8), .DEPTH(32), .CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_imm       (cmd_imm),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_din       (stk_din),
        .stk_dout      (stk_dout),
        .result        (result),
        .result_valid  (result_valid),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .depth         (depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural LIFO with combinational top-of-stack output.
    assign stk_dout = (sp > 0) ? mem[sp-1] : 8'h00;
    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
        end else if (stk_push && sp < 32) begin
            mem[sp] <= stk_din;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns 0 for NOP (no completion expected).
    function automatic bit model(input logic [2:0] op, input logic [7:0] imm, output evt_t e);
        int a, b, d;
        d = mstk.size();
        e = '{kind: 0, value: 0, dep: d, cyc: 0, pops: 0, pushes: 0};
        case (op)
            NOP: return 0;
            PUSH: begin
                if (d == 32) begin e.kind = 2; e.cyc = 1; end
                else begin
                    mstk.push_back(int'(imm));
                    e.value = int'(imm); e.cyc = 2; e.pushes = 1;
                end
            end
            POP: begin
                if (d < 1) begin e.kind = 1; e.cyc = 1; end
                else begin e.value = mstk.pop_back(); e.cyc = 2; e.pops = 1; end
            end
            NOT_: begin
                if (d < 1) begin e.kind = 1; e.cyc = 1; end
                else begin
                    a = mstk.pop_back();
                    e.value = (~a) & 8'hFF;
                    mstk.push_back(e.value);
                    e.cyc = 3; e.pops = 1; e.pushes = 1;
                end
            end
            default: begin
                if (d < 2) begin e.kind = 1; e.cyc = 1; end
                else begin
                    a = mstk.pop_back();
                    b = mstk.pop_back();
                    case (op)
                        ADD:     e.value = (b + a) & 8'hFF;
                        SUB:     e.value = (b - a) & 8'hFF;
                        AND_:    e.value = b & a;
                        default: e.value = b | a;
                    endcase
                    mstk.push_back(e.value);
                    e.cyc = 4; e.pops = 2; e.pushes = 1;
                end
            end
        endcase
        e.dep = mstk.size();
        return 1;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [7:0] imm, input bit track);
        evt_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check_eq("ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        if (track && model(op, imm, e)) begin
            e.cyc = cyc + e.cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble inputs while busy; the sequencer must ignore them.
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_imm   = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mstk.delete();
    endtask

    // Monitor: strobe exclusivity every cycle, scoreboard compare on every completion/error pulse.
    always @(negedge clk) begin
        evt_t e;
        int   kind;
        if (stk_push || stk_pop) check_eq("push_pop_excl", {31'b0, stk_push & stk_pop}, 0);
        if (rst) begin
            pops_seen   = 0;
            pushes_seen = 0;
        end else begin
            if (stk_pop)  pops_seen++;
            if (stk_push) pushes_seen++;
            if (result_valid || err_underflow || err_overflow) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    kind = err_overflow ? 2 : (err_underflow ? 1 : 0);
                    check_eq("one_pulse", int'(result_valid) + int'(err_underflow) + int'(err_overflow), 1);
                    check_eq("kind", kind, e.kind);
                    if (e.kind == 0) check_eq("result", {24'b0, result}, e.value);
                    check_eq("depth", {26'b0, depth}, e.dep);
                    check_eq("latency_cycle", cyc, e.cyc);
                    check_eq("pop_count", pops_seen, e.pops);
                    check_eq("push_count", pushes_seen, e.pushes);
                end
                pops_seen   = 0;
                pushes_seen = 0;
            end
        end
    end

    initial begin
        do_reset();
        @(negedge clk);
        check_eq("rst_depth", {26'b0, depth}, 0);
        check_eq("rst_result", {24'b0, result}, 0);
        check_eq("rst_pulses", {29'b0, result_valid, err_underflow, err_overflow}, 0);
        check_eq("rst_strobes", {30'b0, stk_push, stk_pop}, 0);
        check_eq("rst_ready", {31'b0, cmd_ready}, 1);

        // First PUSH: strobe and data visible one cycle after accept.
        drive(PUSH, 8'h05, 1);
        @(negedge clk);
        check_eq("push1_strobe", {31'b0, stk_push}, 1);
        check_eq("push1_din", {24'b0, stk_din}, 32'h05);
        drain();

        // SUB ordering: B - A with A on top.
        do_reset();
        drive(PUSH, 8'h07, 1);
        drive(PUSH, 8'h03, 1);
        drive(SUB, 8'h00, 1);
        drain();

        // Wrap-around ADD then NOT; NOP must produce nothing.
        do_reset();
        drive(PUSH, 8'hFF, 1);
        drive(PUSH, 8'h02, 1);
        drive(ADD, 8'h00, 1);
        drive(NOT_, 8'h00, 1);
        drive(NOP, 8'h00, 1);
        drive(PUSH, 8'h01, 1);
        drive(PUSH, 8'h02, 1);
        drive(SUB, 8'h00, 1);
        drive(PUSH, 8'hF0, 1);
        drive(PUSH, 8'h3C, 1);
        drive(AND_, 8'h00, 1);
        drive(PUSH, 8'h0F, 1);
        drive(OR_, 8'h00, 1);
        drive(POP, 8'h00, 1);
        drain();

        // Underflow rejections.
        do_reset();
        drive(POP, 8'h00, 1);
        drive(NOT_, 8'h00, 1);
        drive(PUSH, 8'h11, 1);
        drive(ADD, 8'h00, 1);
        drive(OR_, 8'h00, 1);
        drive(NOT_, 8'h00, 1);
        drain();

        // Fill to capacity, overflow, then read back the last entry.
        do_reset();
        for (int i = 0; i < 32; i++) drive(PUSH, 8'(i * 7 + 3), 1);
        drive(PUSH, 8'hAA, 1);
        drive(POP, 8'h00, 1);
        drain();

        // Reset during FETCH_B abandons the ADD.
        do_reset();
        drive(PUSH, 8'h09, 1);
        drive(PUSH, 8'h0A, 1);
        drive(ADD, 8'h00, 0);
        @(negedge clk);
        check_eq("abort_fetch_a_pop", {31'b0, stk_pop}, 1);
        @(negedge clk);
        check_eq("abort_fetch_b_pop", {31'b0, stk_pop}, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("abort_depth", {26'b0, depth}, 0);
        check_eq("abort_no_push", {31'b0, stk_push}, 0);
        check_eq("abort_no_valid", {31'b0, result_valid}, 0);
        check_eq("abort_ready", {31'b0, cmd_ready}, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        mstk.delete();
        repeat (5) @(negedge clk);
        drive(PUSH, 8'h42, 1);
        drive(POP, 8'h00, 1);
        drive(POP, 8'h00, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Initiator side of the 8-bit LIFO stack interface. It accepts one stack-machine command at a time over a valid/ready handshake.
- It drives the stack's push/pop/data-in strobes and samples the stack's combinational top-of-stack output.
- Binary and unary operations are performed on popped operands and the result is pushed back.
- It tracks stack depth to reject overflow/underflow before the stack is touched. It sits between the instruction decoder and the stack in the stack-based datapath.

Parameters:
- DATA_W, 8, operand/stack word width.
- DEPTH, 32, capacity of the attached stack in entries.
- CNT_W, 6, depth counter width; must hold 0..DEPTH inclusive.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- cmd_op  in  3  opcode, see Behaviour.
- cmd_imm  in  DATA_W  immediate for PUSH.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_din  out  DATA_W  data to stack; meaningful only while stk_push=1.
- stk_dout  in  DATA_W  current top of stack from stack (combinational there).
- result  out  DATA_W  value pushed (PUSH/ALU) or popped (POP).
- result_valid  out  1  one-cycle pulse, command completed OK.
- err_underflow  out  1  one-cycle pulse, command rejected (too few entries).
- err_overflow  out  1  one-cycle pulse, PUSH rejected (stack full).
- depth  out  CNT_W  current entry count.

Behaviour:
- Opcodes:
  - 000 NOP: no stack access, no pulses.
  - 001 PUSH imm.
  - 010 POP: result = top.
  - 011 ADD, 100 SUB, 101 AND, 110 OR: binary. A = top, B = second; result = B op A; SUB = B - A.
  - 111 NOT: unary, result = ~A.
- Arithmetic is DATA_W-bit and wraps mod 2^DATA_W; no carry/flags.
- Handshake: the command is accepted on a rising edge with cmd_valid & cmd_ready. cmd_op/cmd_imm are latched at accept; inputs are ignored while busy.
- FSM states: IDLE, FETCH_A, FETCH_B, WRITE.
  - IDLE: cmd_ready=1. On accept, choose the next state:
    - PUSH -> WRITE.
    - POP/NOT -> FETCH_A.
    - binary -> FETCH_A.
    - NOP -> IDLE.
    - rejected command -> IDLE.
  - FETCH_A: stk_pop=1; A <= stk_dout. Next state: POP -> IDLE; NOT -> WRITE; binary -> FETCH_B.
  - FETCH_B: stk_pop=1; B <= stk_dout (the new top after the pop). Next state -> WRITE.
  - WRITE: stk_push=1; stk_din = imm (PUSH) or ALU result. Next state -> IDLE.
- stk_push and stk_pop are never high in the same cycle; both are decoded from state only.
- result_valid pulses in the cycle after the final strobe, i.e. the first IDLE cycle. result holds its value until the next completion.
- Latency from the accept edge to the result_valid cycle: PUSH 2, POP 2, NOT 3, binary 4 cycles.
- depth changes by exactly -1 per stk_pop cycle and +1 per stk_push cycle, registered at the same edge the stack updates.
- Checks are made at accept against the current depth:
  - PUSH with depth==DEPTH -> err_overflow.
  - POP/NOT with depth<1 -> err_underflow.
  - binary with depth<2 -> err_underflow.
  - Rejected commands produce no strobes and no depth change. The error pulse occurs in the next cycle (back in IDLE, cmd_ready=1).
- Back-to-back commands: a new command may be accepted in the same cycle result_valid pulses.
- Reset (including mid-operation): state=IDLE, depth=0, A=B=0, result=0, all strobes and pulses 0. Any op in progress is abandoned. The attached stack is treated as empty after reset.

Decomposition:
- Package stack_seq_pkg holds:
  - typedef enum op_e (the 8 opcodes).
  - typedef enum state_e (IDLE, FETCH_A, FETCH_B, WRITE).
  - localparams DATA_W, DEPTH.
- One sub-module, stack_alu: combinational, (op, a, b) -> y. It covers ADD/SUB/AND/OR/NOT and the PUSH pass-through of imm.

Test Plan:
- Reset, then PUSH 8'h05 -> stk_push high at cycle 1 with stk_din=05; result_valid at cycle 2 with result=05; depth=1.
- PUSH 07, PUSH 03, SUB -> stk_pop in 2 consecutive cycles, then stk_push with din=04; result=04; depth=1.
- PUSH FF, PUSH 02, ADD -> result=01 (wrap); then NOT -> result=FE; depth=1.
- From reset, POP -> err_underflow pulse at cycle 1; no strobes; depth=0. With depth=1, ADD -> err_underflow; depth stays 1.
- 32 PUSHes, then a 33rd PUSH AA -> err_overflow, no stk_push, depth=32. Then POP -> result = 32nd value; depth=31.
- Assert rst in the FETCH_B cycle of ADD (depth 2) -> next cycle IDLE, depth=0, no stk_push, no result_valid. Check the invariant that stk_push&stk_pop are never both 1 throughout.
